// File: rtl/mux_rr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Four-requester round-robin arbiter that steers one of four data lanes onto
//   a shared registered output. An owner keeps the grant for up to MAX_HOLD
//   consecutive cycles. On release, the grant moves straight to the next
//   requester in circular order, with no idle cycle between owners.
//
// Ports
//   clk    in   1          sole clock, rising edge
//   rst    in   1          synchronous, active-high reset
//   req    in   4          req[i] = requester i wants the mux path
//   d      in   4*WIDTH    data lanes, lane i = d[i*WIDTH +: WIDTH]
//   gnt    out  4          registered one-hot grant, 0 when no owner
//   sel    out  2          registered index of current or last owner
//   o      out  WIDTH      registered lane sel, one cycle behind gnt
//   valid  out  1          registered, high when o carries granted data
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4   // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   d,
  output logic [3:0]           gnt,
  output logic [1:0]           sel,
  output logic [WIDTH-1:0]     o,
  output logic                 valid
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             valid_q, valid_d;

  logic [1:0]       search_base;
  logic             do_search;
  logic [2:0]       win;          // {found, index}

  // Circular search: the first requester at base, base+1, ... (mod 4).
  // Because the search wraps, it can return the releasing owner itself when
  // nobody else is asking, which gives a continuous re-grant.
  function automatic logic [2:0] find_winner(input logic [3:0] r,
                                             input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int j = 0; j < 4; j++) begin
      idx = base + 2'(j);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While BUSY, sel_q always holds the index of the current owner.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    search_base = ptr_q;
    do_search   = 1'b0;

    unique case (state_q)
      IDLE: do_search = 1'b1;
      BUSY: begin
        if (req[sel_q] && (cnt_q < MAX_HOLD_C)) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // Release: advance the pointer past the owner, and search from the
          // new pointer in this same cycle.
          ptr_d       = sel_q + 2'd1;
          search_base = sel_q + 2'd1;
          do_search   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    win = find_winner(req, search_base);

    if (do_search) begin
      if (win[2]) begin
        gnt_d   = 4'b0001 << win[1:0];
        sel_d   = win[1:0];
        cnt_d   = 4'd1;
        state_d = BUSY;
      end else begin
        gnt_d   = 4'b0000;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    end
  end

  // Data stage. It is driven from the registered grant, so o and valid trail
  // gnt by exactly one cycle.
  always_comb begin
    valid_d = |gnt_q;
    o_d     = '0;
    if (|gnt_q) o_d = d[int'(sel_q)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from the same pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign o     = o_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
`timescale 1ns/1ps
// Testbench for mux_rr_arbiter. Every cycle's expected outputs are predicted
// by a behavioural model when the stimulus is driven. The prediction is queued
// and then popped and compared after the clock edge. The scenario tasks also
// compare the grant pattern against fixed expected values.
module tb_mux_rr_arbiter;

  localparam int WIDTH    = 3;
  localparam int MAX_HOLD = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           req;
  logic [4*WIDTH-1:0]   d;
  logic [3:0]           gnt;
  logic [1:0]           sel;
  logic [WIDTH-1:0]     o;
  logic                 valid;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .gnt(gnt), .sel(sel), .o(o), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] o;
    logic             valid;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Model state.
  bit               m_busy  = 0;
  int               m_owner = 0;
  int               m_cnt   = 0;
  int               m_ptr   = 0;
  logic [3:0]       m_gnt   = '0;
  logic [1:0]       m_sel   = '0;
  logic [WIDTH-1:0] m_o     = '0;
  logic             m_valid = 1'b0;

  function automatic logic [WIDTH-1:0] lane(input logic [4*WIDTH-1:0] dv,
                                            input int i);
    return dv[i*WIDTH +: WIDTH];
  endfunction

  // Advances the model by one rising edge, using the inputs that are driven now.
  task automatic model_step();
    int  base;
    bit  search;
    bit  found;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      m_gnt = '0; m_sel = '0; m_o = '0; m_valid = 1'b0;
      return;
    end
    m_valid = (m_gnt != 4'b0000);
    m_o     = m_valid ? lane(d, int'(m_sel)) : '0;
    search  = 0;
    base    = m_ptr;
    if (!m_busy) begin
      search = 1;
    end else if (req[m_owner] && m_cnt < MAX_HOLD) begin
      m_cnt = m_cnt + 1;
    end else begin
      m_ptr  = (m_owner + 1) % 4;
      base   = m_ptr;
      search = 1;
    end
    if (search) begin
      found = 0;
      for (int j = 0; j < 4; j++) begin
        if (!found && req[(base + j) % 4]) begin
          found   = 1;
          m_owner = (base + j) % 4;
        end
      end
      if (found) begin
        m_busy = 1; m_cnt = 1;
        m_gnt  = 4'(1 << m_owner);
        m_sel  = 2'(m_owner);
      end else begin
        m_busy = 0; m_cnt = 0; m_gnt = '0;
      end
    end
  endtask

  // Drives one cycle of stimulus, queues the prediction, then scores the DUT
  // just after the edge.
  task automatic drive(input logic r, input logic [3:0] rq,
                       input logic [4*WIDTH-1:0] dv);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; d = dv;
    model_step();
    sb_q.push_back('{gnt: m_gnt, sel: m_sel, o: m_o, valid: m_valid});
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    checks++;
    if (gnt !== e.gnt) begin
      failures++;
      $display("FAIL sb_gnt cycle=%0d got=%b exp=%b", cyc, gnt, e.gnt);
    end
    checks++;
    if (sel !== e.sel) begin
      failures++;
      $display("FAIL sb_sel cycle=%0d got=%0d exp=%0d", cyc, sel, e.sel);
    end
    checks++;
    if (o !== e.o) begin
      failures++;
      $display("FAIL sb_o cycle=%0d got=%0h exp=%0h", cyc, o, e.o);
    end
    checks++;
    if (valid !== e.valid) begin
      failures++;
      $display("FAIL sb_valid cycle=%0d got=%b exp=%b", cyc, valid, e.valid);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 4'hF, '1);
    drive(1'b1, 4'hF, '1);
    checks++;
    if ({gnt, sel, o, valid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b sel=%0d o=%0h valid=%b exp all 0",
               gnt, sel, o, valid);
    end
  endtask

  // All four requesting: each owner holds for MAX_HOLD edges in turn, 0..3, 0.
  task automatic test_rotation();
    logic [3:0] exp_g;
    drive(1'b1, 4'h0, '0);
    for (int e = 1; e <= 17; e++) begin
      drive(1'b0, 4'hF, (4*WIDTH)'($urandom));
      exp_g = 4'b0001 << (((e - 1) / 4) % 4);
      checks++;
      if (gnt !== exp_g) begin
        failures++;
        $display("FAIL rotation edge=%0d got=%b exp=%b", e, gnt, exp_g);
      end
    end
  endtask

  // A release advances ptr to 3, so the later search wraps round to requester 0.
  task automatic test_release_wrap();
    drive(1'b1, 4'h0, '0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b0100, '0);
      checks++;
      if (gnt !== 4'b0100) begin
        failures++;
        $display("FAIL single_hold i=%0d got=%b exp=0100", i, gnt);
      end
    end
    drive(1'b0, 4'b0000, '0);
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL single_release got=%b exp=0000", gnt);
    end
    drive(1'b0, 4'b0101, '0);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_search got=%b exp=0001", gnt);
    end
  endtask

  // A lone requester is re-granted at MAX_HOLD with no gap.
  task automatic test_hold_wrap();
    drive(1'b1, 4'h0, '0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'b0010, '0);
      checks++;
      if (gnt !== 4'b0010) begin
        failures++;
        $display("FAIL hold_wrap cycle=%0d got=%b exp=0010", i, gnt);
      end
    end
  endtask

  task automatic test_data();
    logic [4*WIDTH-1:0] dv;
    dv = '0;
    dv[WIDTH +: WIDTH] = WIDTH'(1);
    drive(1'b1, 4'h0, dv);
    drive(1'b0, 4'b0010, dv);
    drive(1'b0, 4'b0010, dv);
    checks++;
    if (o !== WIDTH'(1) || valid !== 1'b1) begin
      failures++;
      $display("FAIL data_lane1 got o=%0h valid=%b exp o=1 valid=1", o, valid);
    end
    drive(1'b0, 4'b0000, dv);
    drive(1'b0, 4'b0000, dv);
    checks++;
    if (o !== '0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL data_drop got o=%0h valid=%b exp o=0 valid=0", o, valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'h0, '0);
    for (int i = 0; i < 14; i++) drive(1'b0, 4'hF, '1);  // owner 3, cnt 2
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL pre_reset_owner got=%b exp=1000", gnt);
    end
    drive(1'b1, 4'hF, '1);
    checks++;
    if ({gnt, sel, o, valid} !== '0) begin
      failures++;
      $display("FAIL mid_reset got gnt=%b sel=%0d o=%0h valid=%b exp all 0",
               gnt, sel, o, valid);
    end
    drive(1'b0, 4'hF, '1);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_priority got=%b exp=0001", gnt);
    end
  endtask

  // Owner 0 drops its request while 2 waits: back-to-back handoff.
  task automatic test_back_to_back();
    logic [4*WIDTH-1:0] dv;
    dv = '0;
    dv[0 +: WIDTH]       = WIDTH'(2);
    dv[2*WIDTH +: WIDTH] = WIDTH'(5);
    drive(1'b1, 4'h0, dv);
    drive(1'b0, 4'b0101, dv);
    drive(1'b0, 4'b0100, dv);
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      failures++;
      $display("FAIL handoff got gnt=%b sel=%0d exp gnt=0100 sel=2", gnt, sel);
    end
    drive(1'b0, 4'b0100, dv);
    checks++;
    if (o !== WIDTH'(5) || valid !== 1'b1) begin
      failures++;
      $display("FAIL handoff_data got o=%0h valid=%b exp o=5 valid=1", o, valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), 4'($urandom),
            (4*WIDTH)'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    d   = '0;
    test_reset();
    test_rotation();
    test_release_wrap();
    test_hold_wrap();
    test_data();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data lane.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive cycles one requester keeps the grant; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  4  request per requester; req[i] high = requester i wants the shared mux path.
REQ-006 d  input  4*WIDTH  data lanes; lane i = d[i*WIDTH +: WIDTH].
REQ-007 gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-008 sel  output  2  registered binary index of current or last owner; drives the 4:1 mux select.
REQ-009 o  output  WIDTH  registered mux output: lane sel, sampled while a grant is active.
REQ-010 valid  output  1  registered; high when o carries granted data.

Function
REQ-011 Internal state SHALL be: FSM {IDLE, BUSY}; 2-bit priority pointer ptr; hold counter cnt, 4 bits.
REQ-012 Winner search SHALL be circular: first i with req[i]=1 in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE, req==0: gnt stays 0000; sel holds its value; state stays IDLE.
REQ-014 IDLE, req!=0 at edge N: after edge N, gnt = one-hot(winner), sel = winner, cnt = 1, state = BUSY. Request-to-grant latency is 1 cycle.
REQ-015 BUSY, owner k keeps the grant while req[k]=1 and cnt<MAX_HOLD; cnt increments by 1 per cycle.
REQ-016 Release condition: req[k]=0 or cnt==MAX_HOLD.
REQ-017 On release, ptr = k+1 mod 4; the search then uses this new ptr in the same cycle.
REQ-018 Release with another request pending: grant moves directly to the new winner on the same edge, cnt = 1. No idle cycle between owners.
REQ-019 Release with no request pending: gnt = 0000, state = IDLE, cnt = 0.
REQ-020 cnt==MAX_HOLD with req[k]=1 and no other request: k is re-granted (wrap-around search returns k); gnt stays continuously high; cnt = 1.
REQ-021 gnt SHALL never have more than one bit set; sel SHALL always equal the index of the set gnt bit whenever gnt!=0.
REQ-022 Data stage, every edge: valid <= |gnt; o <= lane sel if |gnt, else 0. o/valid lag gnt by exactly 1 cycle.
REQ-023 Requests from non-owners during BUSY SHALL have no effect until release; no request is latched; a requester that drops req before being granted is forgotten.

Reset
REQ-024 When rst is high at a rising edge: gnt=0000, sel=00, o=0, valid=0, ptr=0, cnt=0, state=IDLE. rst overrides all other inputs.
REQ-025 Reset mid-BUSY drops the grant at that edge with no completion of the hold.
REQ-026 After rst deasserts, requester 0 has highest priority.

Verification
REQ-027 After reset, req=1111 held, MAX_HOLD=4 -> gnt=0001 for edges 1-4, then 0010 for edges 5-8, then 0100, then 1000, then 0001 again; no 0000 cycle between owners.
REQ-028 Only req=0100 is asserted for 2 cycles, then req=0000 -> gnt=0100 for 2 cycles, then 0000 with state IDLE. A following req=0101 -> gnt=0001, because ptr=3 and the search wraps to 0.
REQ-029 Only req=0010 is held for 10 cycles, MAX_HOLD=4 -> gnt=0010 is continuous for all 10 cycles; cnt sequence is 1,2,3,4,1,2,3,4,1,2.
REQ-030 Data path: gnt=0010 with lane1=1 and all other lanes 0 -> the next cycle shows o=1, valid=1. When the grant drops, the following cycle shows o=0, valid=0.
REQ-031 rst=1 while gnt=1000 and cnt=2 -> at the next edge all outputs are 0. With req=1111 after release, the first grant is 0001.
REQ-032 Owner 0 drops req while req[2]=1 -> gnt goes 0001 to 0100 on the same edge; sel=10; the next cycle shows o = lane2.
